// File: rtl/structure_reduce_channel_pipelined_adds.sv
// -----------------------------------------------------------------------------
// structure_reduce_channel_pipelined_adds
//
// Channel-reduce stage for the structure-reduce datapath. Every valid input
// word passes through a fixed chain of NUM_ADDS combinational "+INC" adders
// and the sum is captured in a single output register. The register holds its
// value while in_valid is low, so downstream logic always sees the last
// reduced word. There is no backpressure: one word per clock is accepted.
//
// Parameters:
//   WIDTH     data width of in_data and result
//   NUM_ADDS  number of chained +INC adder stages (must be >= 1)
//   INC       WIDTH-bit constant added by each stage
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset (0 = reset asserted)
//   in_valid   qualifies in_data this cycle
//   in_data    input word
//   result     registered reduced value (in_data + NUM_ADDS*INC, wrapping)
//   out_valid  high for the cycle after a valid input was captured
// -----------------------------------------------------------------------------
module structure_reduce_channel_pipelined_adds #(
    parameter int               WIDTH    = 16,
    parameter int               NUM_ADDS = 2,
    parameter logic [WIDTH-1:0] INC      = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] result,
    output logic             out_valid
);

    // A chain with no adders would silently turn this stage into a plain
    // register; refuse to build it.
    if (NUM_ADDS < 1) begin : g_num_adds_check
        $error("structure_reduce_channel_pipelined_adds: NUM_ADDS must be >= 1");
    end

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Adder chain. Each stage is WIDTH bits wide, so the carry out of every
    // stage is dropped and the running value wraps modulo 2^WIDTH.
    always_comb begin
        logic [WIDTH-1:0] acc;
        acc = in_data;
        for (int i = 0; i < NUM_ADDS; i++) begin
            acc = acc + INC;
        end
        sum = acc;
    end

    // Next-state logic. The mux select is in_valid, so an unknown in_data
    // while the channel is idle never reaches the register.
    always_comb begin
        // NOTE: every signal gets a default before any condition so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        result_d    = result_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d = sum;
        end
    end

    // Output register: the only clocked element; reset clears it at once,
    // discarding whatever word was held.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples its inputs from before the edge, regardless of block order.
        if (!rst) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_structure_reduce_channel_pipelined_adds.sv
// -----------------------------------------------------------------------------
// Testbench for structure_reduce_channel_pipelined_adds.
//
// The stimulus process drives the channel one clock at a time (inputs change
// 1 time unit after the rising edge) and pushes the expected reduced word for
// every valid input into a scoreboard queue. A separate monitor samples on the
// falling edge: when out_valid is high it pops and compares, otherwise it
// checks that result holds the last delivered value (or 0 during reset).
// -----------------------------------------------------------------------------
module tb_structure_reduce_channel_pipelined_adds;

    localparam int          WIDTH    = 16;
    localparam int          NUM_ADDS = 2;
    localparam logic [15:0] INC      = 16'd1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic [WIDTH-1:0]  result;
    logic              out_valid;

    int                checks = 0;
    int                errors = 0;
    logic [WIDTH-1:0]  exp_q[$];
    logic [WIDTH-1:0]  hold_val = '0;

    structure_reduce_channel_pipelined_adds #(
        .WIDTH    (WIDTH),
        .NUM_ADDS (NUM_ADDS),
        .INC      (INC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .result    (result),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the word plus the total offset, reduced modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d);
        longint s;
        s = longint'(d) + longint'(NUM_ADDS) * longint'(INC);
        return WIDTH'(s % 65536);
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Apply one input word and advance to 1 unit after the capturing edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_data  = d;
        if (v && rst) exp_q.push_back(model(d));
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, confirm it clears without a clock, hold it
    // across one edge, then release it away from any edge.
    task automatic mid_reset();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_result", result, '0);
        check("async_reset_out_valid", {15'b0, out_valid}, '0);
        @(posedge clk);
        #1;
        check("reset_held_result", result, '0);
        rst = 1'b1;
    endtask

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                hold_val = '0;
                check("mon_reset_result", result, '0);
                check("mon_reset_out_valid", {15'b0, out_valid}, '0);
            end else if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_valid: got out_valid=1 with result %0d, expected no output at %0t",
                             result, $time);
                end else begin
                    hold_val = exp_q.pop_front();
                    check("sb_result", result, hold_val);
                end
            end else begin
                check("mon_hold_result", result, hold_val);
            end
        end
    end

    // Stimulus.
    initial begin
        logic             v;
        logic [WIDTH-1:0] d;

        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd99;
        repeat (4) @(posedge clk);
        #1;
        check("reset_result", result, '0);
        check("reset_out_valid", {15'b0, out_valid}, '0);

        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("release_no_edge", result, '0);
        cycle(1'b0, 16'd99);
        check("idle_after_release", result, '0);
        check("idle_after_release_ov", {15'b0, out_valid}, '0);

        cycle(1'b1, 16'd10);
        check("single_valid", result, 16'd12);
        check("single_valid_ov", {15'b0, out_valid}, 16'd1);
        cycle(1'b1, 16'd15);
        check("back_to_back", result, 16'd17);
        cycle(1'b0, 16'd18);
        check("hold_1", result, 16'd17);
        check("hold_1_ov", {15'b0, out_valid}, '0);
        cycle(1'b0, 'x);
        check("hold_x_data", result, 16'd17);

        cycle(1'b1, 16'd65535);
        check("wrap_max", result, 16'd1);
        cycle(1'b1, 16'd65534);
        check("wrap_max_minus_1", result, 16'd0);

        cycle(1'b1, 16'd15);
        check("pre_reset_value", result, 16'd17);
        mid_reset();
        cycle(1'b1, 16'd5);
        check("after_mid_reset", result, 16'd7);
        cycle(1'b0, 16'd0);
        check("after_mid_reset_hold", result, 16'd7);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            v = ($urandom_range(0, 3) != 0);
            d = WIDTH'($urandom);
            if (!v && $urandom_range(0, 3) == 0) d = 'x;
            cycle(v, d);
        end

        cycle(1'b0, 16'd0);
        cycle(1'b0, 16'd0);
        check("queue_drained", WIDTH'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
